// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared types and helpers for the clkgen_multi clock generator
//
// Purpose : configuration record type and the reset-time half-period
//           calculation used by every channel.
// Contents: CFG_BITS default field width, clkgen_cfg_t {high, low},
//           rst_half() clamp helper, ch_bits() channel-select width helper.
package clkgen_pkg;

    localparam int CFG_BITS = 16;

    typedef struct packed {
        logic [CFG_BITS-1:0] high;
        logic [CFG_BITS-1:0] low;
    } clkgen_cfg_t;

    // Half of the divide ratio, clamped so it is never zero and always fits
    // in a phase counter of the given width.
    function automatic longint rst_half(input longint main_hz, input longint clk_hz,
                                        input int bits);
        longint half;
        longint max_len;
        half    = (clk_hz > 0) ? (main_hz / clk_hz / 2) : 1;
        max_len = (longint'(1) << bits) - 1;
        if (half < 1) half = 1;
        if (half > max_len) half = max_len;
        return half;
    endfunction

    // Width of a channel index; a single channel still gets one select bit.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkgen_ch.sv
// rtl/clkgen_ch.sv - one divided-clock channel with shadowed phase lengths
//
// Purpose : generates one divided clock from in_clk. Phase lengths live in an
//           active pair that only changes at a period boundary (or while
//           idle/realigned), fed from a shadow pair written by the top.
// Ports   : in_clk, in_rst   main clock, synchronous active-high reset
//           en               channel enable (idle at CLK_INIT when low)
//           sync             phase-restart request (tied low when unused)
//           wr_en            accepted config write for this channel
//           wr_high, wr_low  new phase lengths for the shadow registers
//           pending          shadow holds a config not yet applied
//           level            generated clock
//           rise             one-cycle strobe in the first cycle level is 1
module clkgen_ch
    import clkgen_pkg::*;
#(
    parameter int MAIN_CLK_HZ = 50_000_000,
    parameter int CLK_HZ      = 10_000,
    parameter bit CLK_INIT    = 1'b0,
    parameter int CTR_BITS    = 16
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                en,
    input  logic                sync,
    input  logic                wr_en,
    input  logic [CTR_BITS-1:0] wr_high,
    input  logic [CTR_BITS-1:0] wr_low,
    output logic                pending,
    output logic                level,
    output logic                rise
);

    localparam logic [CTR_BITS-1:0] RST_HALF =
        CTR_BITS'(rst_half(longint'(MAIN_CLK_HZ), longint'(CLK_HZ), CTR_BITS));

    logic [CTR_BITS-1:0] cnt;
    logic [CTR_BITS-1:0] act_high;
    logic [CTR_BITS-1:0] act_low;
    logic [CTR_BITS-1:0] sh_high;
    logic [CTR_BITS-1:0] sh_low;

    logic [CTR_BITS-1:0] phase_len;
    logic [CTR_BITS-1:0] last_cnt;
    logic                toggle;
    logic                boundary;
    logic                apply;

    always_comb begin
        phase_len = level ? act_high : act_low;
        // A zero length behaves as one cycle: the last count is then 0.
        last_cnt  = (phase_len == '0) ? '0 : (phase_len - CTR_BITS'(1));
        toggle    = en && !sync && (cnt == last_cnt);
        // Toggling away from the non-idle level ends the period.
        boundary  = toggle && (level != CLK_INIT);
        // Idle and realigned channels take a pending config immediately.
        apply     = pending && (!en || sync || boundary);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            level    <= CLK_INIT;
            rise     <= 1'b0;
            cnt      <= '0;
            act_high <= RST_HALF;
            act_low  <= RST_HALF;
            sh_high  <= RST_HALF;
            sh_low   <= RST_HALF;
            pending  <= 1'b0;
        end else begin
            if (!en || sync) begin
                level <= CLK_INIT;
                cnt   <= '0;
                rise  <= 1'b0;
            end else if (toggle) begin
                level <= !level;
                cnt   <= '0;
                rise  <= !level;
            end else begin
                cnt   <= cnt + CTR_BITS'(1);
                rise  <= 1'b0;
            end

            if (apply) begin
                act_high <= sh_high;
                act_low  <= sh_low;
            end

            // wr_en is only raised while pending is clear, so it never
            // collides with apply in the same cycle.
            if (wr_en) begin
                sh_high <= wr_high;
                sh_low  <= wr_low;
            end
            pending <= wr_en || (pending && !apply);
        end
    end

endmodule

// File: rtl/clkgen_multi.sv
// rtl/clkgen_multi.sv - multi-channel runtime-programmable clock generator
//
// Purpose : NUM_CH independent divided clocks with per-channel enable,
//           rising-edge strobe and a valid/ready config port whose writes
//           take effect at the addressed channel's next period boundary.
// Option  : CLKGEN_SYNC_EN adds in_sync, a pulse that restarts every enabled
//           channel phase-aligned and applies pending configs.
// Ports   : in_clk, in_rst          main clock, synchronous active-high reset
//           in_sync                 phase-restart pulse (CLKGEN_SYNC_EN only)
//           in_en                   per-channel enable
//           in_cfg_valid            config request
//           out_cfg_ready           config accepted this cycle if valid
//           in_cfg_ch               target channel (out-of-range is dropped)
//           in_cfg_high, in_cfg_low phase lengths in in_clk cycles
//           out_clk                 generated clocks
//           out_rise                first-cycle-high strobe per channel
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter  int MAIN_CLK_HZ = 50_000_000,
    parameter  int CLK_HZ      = 10_000,
    parameter  bit CLK_INIT    = 1'b0,
    parameter  int NUM_CH      = 2,
    parameter  int CTR_BITS    = 16,
    localparam int CH_W        = ch_bits(NUM_CH)
) (
    input  logic                in_clk,
    input  logic                in_rst,
`ifdef CLKGEN_SYNC_EN
    input  logic                in_sync,
`endif
    input  logic [NUM_CH-1:0]   in_en,
    input  logic                in_cfg_valid,
    output logic                out_cfg_ready,
    input  logic [CH_W-1:0]     in_cfg_ch,
    input  logic [CTR_BITS-1:0] in_cfg_high,
    input  logic [CTR_BITS-1:0] in_cfg_low,
    output logic [NUM_CH-1:0]   out_clk,
    output logic [NUM_CH-1:0]   out_rise
);

    logic              sync;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_en;
    logic              cfg_ready;

`ifdef CLKGEN_SYNC_EN
    assign sync = in_sync;
`else
    assign sync = 1'b0;
`endif

    // Ready follows the addressed channel; an out-of-range channel matches
    // nothing, so ready stays high and the write lands nowhere.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
        end
    end

    assign out_cfg_ready = cfg_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_en[g] = in_cfg_valid && (in_cfg_ch == CH_W'(g)) && !pending[g];

        clkgen_ch #(
            .MAIN_CLK_HZ(MAIN_CLK_HZ),
            .CLK_HZ     (CLK_HZ),
            .CLK_INIT   (CLK_INIT),
            .CTR_BITS   (CTR_BITS)
        ) u_ch (
            .in_clk (in_clk),
            .in_rst (in_rst),
            .en     (in_en[g]),
            .sync   (sync),
            .wr_en  (wr_en[g]),
            .wr_high(in_cfg_high),
            .wr_low (in_cfg_low),
            .pending(pending[g]),
            .level  (out_clk[g]),
            .rise   (out_rise[g])
        );
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// tb/tb_clkgen_multi.sv - self-checking bench for clkgen_multi
module tb_clkgen_multi;
    import clkgen_pkg::*;

    localparam int NCH = 3;
    localparam int RST_LEN = 5;

    logic            in_clk = 1'b0;
    logic            in_rst;
    logic            in_sync;
    logic [NCH-1:0]  in_en;
    logic            in_cfg_valid;
    logic            out_cfg_ready;
    logic [1:0]      in_cfg_ch;
    logic [15:0]     in_cfg_high;
    logic [15:0]     in_cfg_low;
    logic [NCH-1:0]  out_clk;
    logic [NCH-1:0]  out_rise;

    always #5 in_clk = ~in_clk;

    clkgen_multi #(
        .MAIN_CLK_HZ(1000),
        .CLK_HZ     (100),
        .CLK_INIT   (1'b0),
        .NUM_CH     (NCH),
        .CTR_BITS   (16)
    ) dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
`ifdef CLKGEN_SYNC_EN
        .in_sync      (in_sync),
`endif
        .in_en        (in_en),
        .in_cfg_valid (in_cfg_valid),
        .out_cfg_ready(out_cfg_ready),
        .in_cfg_ch    (in_cfg_ch),
        .in_cfg_high  (in_cfg_high),
        .in_cfg_low   (in_cfg_low),
        .out_clk      (out_clk),
        .out_rise     (out_rise)
    );

    int errors = 0;
    int checks = 0;
    int n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: each channel tracks its position within the current
    // period; the output is high once the position reaches the low length.
    int m_h[NCH], m_l[NCH], m_sh[NCH], m_sl[NCH], m_pos[NCH];
    bit m_pend[NCH], m_out[NCH], m_rise[NCH];

    function automatic int eff(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_h[i] = RST_LEN; m_l[i] = RST_LEN; m_sh[i] = RST_LEN; m_sl[i] = RST_LEN;
            m_pos[i] = 0; m_pend[i] = 0; m_out[i] = 0; m_rise[i] = 0;
        end
    endtask

    function automatic bit model_ready();
        if (int'(in_cfg_ch) >= NCH) return 1'b1;
        return !m_pend[in_cfg_ch];
    endfunction

    task automatic model_apply(input int i);
        m_h[i] = m_sh[i]; m_l[i] = m_sl[i]; m_pend[i] = 0;
    endtask

    task automatic model_step();
        bit wr [NCH];
        if (in_rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NCH; i++)
            wr[i] = in_cfg_valid && (int'(in_cfg_ch) == i) && !m_pend[i];
        for (int i = 0; i < NCH; i++) begin
            if (!in_en[i] || in_sync) begin
                m_pos[i] = 0; m_out[i] = 0; m_rise[i] = 0;
                if (m_pend[i]) model_apply(i);
            end else begin
                m_pos[i]++;
                if (m_pos[i] == eff(m_h[i]) + eff(m_l[i])) begin
                    m_pos[i] = 0;
                    if (m_pend[i]) model_apply(i);
                end
                m_out[i]  = (m_pos[i] >= eff(m_l[i]));
                m_rise[i] = (m_pos[i] == eff(m_l[i]));
            end
            if (wr[i]) begin
                m_sh[i] = int'(in_cfg_high); m_sl[i] = int'(in_cfg_low); m_pend[i] = 1;
            end
        end
    endtask

    typedef struct {
        int         n;
        logic [1:0] clk;
        logic [1:0] rise;
    } vec_t;
    vec_t tbl[$];

    task automatic step();
        @(negedge in_clk);
        if (!in_rst) check("ready", out_cfg_ready, model_ready());
        @(posedge in_clk);
        model_step();
        #1;
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("clk%0d@%0d", i, n + 1), out_clk[i], m_out[i]);
            check($sformatf("rise%0d@%0d", i, n + 1), out_rise[i], m_rise[i]);
        end
        if (!in_rst) begin
            n++;
            foreach (tbl[k]) begin
                if (tbl[k].n == n) begin
                    check($sformatf("tbl_clk@%0d", n), out_clk[1:0], tbl[k].clk);
                    check($sformatf("tbl_rise@%0d", n), out_rise[1:0], tbl[k].rise);
                end
            end
        end
    endtask

    task automatic run_to(input int t);
        while (n < t) step();
    endtask

    task automatic cfg(input int ch, input int hi, input int lo);
        clkgen_cfg_t c;
        c.high = 16'(hi);
        c.low  = 16'(lo);
        in_cfg_valid = 1'b1;
        in_cfg_ch    = 2'(ch);
        in_cfg_high  = c.high;
        in_cfg_low   = c.low;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int waited;
        int rises;
        int f0;
        int f1;

        // Hand-derived waveform points: 5/5 from reset, then ch1 runs 2/6
        // from its boundary at cycle 30 while ch0 stays 5/5.
        tbl.push_back(vec_t'{1,  2'b00, 2'b00});
        tbl.push_back(vec_t'{4,  2'b00, 2'b00});
        tbl.push_back(vec_t'{5,  2'b11, 2'b11});
        tbl.push_back(vec_t'{6,  2'b11, 2'b00});
        tbl.push_back(vec_t'{9,  2'b11, 2'b00});
        tbl.push_back(vec_t'{10, 2'b00, 2'b00});
        tbl.push_back(vec_t'{15, 2'b11, 2'b11});
        tbl.push_back(vec_t'{20, 2'b00, 2'b00});
        tbl.push_back(vec_t'{27, 2'b11, 2'b00});
        tbl.push_back(vec_t'{30, 2'b00, 2'b00});
        tbl.push_back(vec_t'{35, 2'b01, 2'b01});
        tbl.push_back(vec_t'{36, 2'b11, 2'b10});
        tbl.push_back(vec_t'{38, 2'b01, 2'b00});
        tbl.push_back(vec_t'{40, 2'b00, 2'b00});
        tbl.push_back(vec_t'{44, 2'b10, 2'b10});
        tbl.push_back(vec_t'{45, 2'b11, 2'b01});
        tbl.push_back(vec_t'{46, 2'b01, 2'b00});

        in_rst = 1'b1; in_sync = 1'b0; in_en = '1;
        in_cfg_valid = 1'b0; in_cfg_ch = '0; in_cfg_high = '0; in_cfg_low = '0;
        model_reset();
        repeat (3) step();
        check("rst_clk", out_clk, 0);
        check("rst_rise", out_rise, 0);
        check("rst_ready", out_cfg_ready, 1);
        in_rst = 1'b0;

        // Reset waveform, then reprogram ch1 mid high phase.
        run_to(27);
        cfg(1, 2, 6);
        step();
        in_cfg_valid = 1'b0;
        run_to(50);

        // Back-to-back writes to ch0: second waits for the boundary.
        cfg(0, 3, 3);
        #1 check("rdy_idle", out_cfg_ready, 1);
        step();
        cfg(0, 1, 1);
        waited = 0;
        while (!out_cfg_ready && waited < 30) begin
            step();
            waited++;
        end
        check("blocked_cycles", waited, 9);
        step();
        in_cfg_valid = 1'b0;
        run_to(63);
        check("b2b_rise63", {31'd0, out_rise[0]}, 1);
        run_to(66);
        check("b2b_low66", {31'd0, out_clk[0]}, 0);
        run_to(67);
        check("b2b_rise67", {31'd0, out_rise[0]}, 1);
        run_to(68);
        check("b2b_low68", {31'd0, out_clk[0]}, 0);

        // Out-of-range channel is always ready and changes nothing.
        cfg(3, 7, 7);
        #1 check("bad_ch_ready", out_cfg_ready, 1);
        step();
        in_cfg_valid = 1'b0;

        // Zero lengths behave as 1/1.
        cfg(2, 0, 0);
        step();
        in_cfg_valid = 1'b0;
        repeat (15) step();
        rises = 0;
        repeat (10) begin
            step();
            rises += int'(out_rise[2]);
        end
        check("zero_rises", rises, 5);

        // Disable while high, idle next cycle, re-enable -> rise after 5.
        cfg(0, 5, 5);
        step();
        in_cfg_valid = 1'b0;
        repeat (12) step();
        waited = 0;
        while (!out_clk[0] && waited < 20) begin
            step();
            waited++;
        end
        check("dis_high_first", {31'd0, out_clk[0]}, 1);
        in_en[0] = 1'b0;
        step();
        check("dis_idle", {31'd0, out_clk[0]}, 0);
        repeat (3) step();
        in_en[0] = 1'b1;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!out_clk[0] && waited < 20);
        check("reen_latency", waited, 5);

`ifdef CLKGEN_SYNC_EN
        cfg(0, 3, 3);
        step();
        cfg(1, 4, 4);
        step();
        in_cfg_valid = 1'b0;
        repeat (20) step();
        in_sync = 1'b1;
        step();
        in_sync = 1'b0;
        check("sync_low", out_clk[1:0], 0);
        f0 = -1;
        f1 = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (out_rise[0] && f0 < 0) f0 = k;
            if (out_rise[1] && f1 < 0) f1 = k;
        end
        check("sync_rise0", f0, 3);
        check("sync_rise1", f1, 4);
`else
        f0 = 0;
        f1 = 0;
`endif

        // Random traffic against the model.
        repeat (600) begin
            if ($urandom_range(0, 15) == 0) begin
                waited = int'($urandom_range(0, NCH - 1));
                in_en[waited] = ~in_en[waited];
            end
            cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 6)));
            in_cfg_valid = ($urandom_range(0, 3) == 0);
`ifdef CLKGEN_SYNC_EN
            in_sync = ($urandom_range(0, 31) == 0);
`endif
            step();
        end
        in_sync = 1'b0;

        // Reset mid-operation with a write in flight.
        cfg(1, 2, 2);
        step();
        in_cfg_valid = 1'b0;
        in_rst = 1'b1;
        step();
        check("mid_rst_clk", out_clk, 0);
        check("mid_rst_rise", out_rise, 0);
        step();
        in_rst = 1'b0;
        in_en = '1;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!out_rise[1] && waited < 20);
        check("mid_rst_first_rise", waited, RST_LEN);
        repeat (12) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
